// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes, multi-cycle dmem holds.
// Control outputs are combinational from state/flush_pend/inputs; state, stall counter and timeout flag are registered.
module pipeline_hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rt_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_stall_o,
   output logic             ifid_stall_o,
   output logic             idex_stall_o,
   output logic             exmem_stall_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             memwb_bubble_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             err_o
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1
   } state_t;

   state_t            state_q, state_d;
   logic              flush_pend_q, flush_pend_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              err_q, err_d;

   logic memstall;
   logic flush_req;
   logic load_use;
   logic rs_match;
   logic rt_match;

   assign memstall  = dmem_req_i & ~dmem_ack_i;
   assign flush_req = ~memstall & (branch_taken_i | flush_pend_q);
   assign rs_match  = (idex_rt_i == ifid_rs_i);
   assign rt_match  = ifid_uses_rt_i & (idex_rt_i == ifid_rt_i);
   // Branch flush outranks load-use: the stalled instruction is being squashed anyway.
   assign load_use  = ~memstall & ~flush_req & idex_memread_i &
                      (idex_rt_i != 5'd0) & (rs_match | rt_match);

   always_comb begin
      pc_stall_o     = 1'b0;
      ifid_stall_o   = 1'b0;
      idex_stall_o   = 1'b0;
      exmem_stall_o  = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_flush_o   = 1'b0;
      memwb_bubble_o = 1'b0;
      if (!rst_i) begin
         pc_stall_o     = memstall | load_use;
         ifid_stall_o   = memstall | load_use;
         idex_stall_o   = memstall;
         exmem_stall_o  = memstall;
         ifid_flush_o   = flush_req;
         idex_flush_o   = flush_req | load_use;
         memwb_bubble_o = memstall;
      end
   end

   always_comb begin
      state_d      = memstall ? ST_MEM_WAIT : ST_RUN;
      flush_pend_d = flush_pend_q;
      if (memstall && branch_taken_i) begin
         flush_pend_d = 1'b1;
      end else if (flush_req) begin
         flush_pend_d = 1'b0;
      end

      // Wait counter rests at zero in RUN so entry to MEM_WAIT starts from 0; it parks at the last value.
      wait_d = wait_q;
      if (state_q == ST_RUN) begin
         wait_d = '0;
      end else if (wait_q != WAIT_LAST) begin
         wait_d = wait_q + WAIT_W'(1);
      end

      err_d = err_q;
      if (state_q == ST_MEM_WAIT && wait_q == WAIT_LAST && !dmem_ack_i) begin
         err_d = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (pc_stall_o && stall_cnt_q != {CNT_W{1'b1}}) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         flush_pend_q <= 1'b0;
         wait_q       <= '0;
         stall_cnt_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         wait_q       <= wait_d;
         stall_cnt_q  <= stall_cnt_d;
         err_q        <= err_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with CNT_W=4 and TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       idex_memread_i;
   logic [4:0] idex_rt_i;
   logic [4:0] ifid_rs_i;
   logic [4:0] ifid_rt_i;
   logic       ifid_uses_rt_i;
   logic       branch_taken_i;
   logic       dmem_req_i;
   logic       dmem_ack_i;
   logic       pc_stall_o;
   logic       ifid_stall_o;
   logic       idex_stall_o;
   logic       exmem_stall_o;
   logic       ifid_flush_o;
   logic       idex_flush_o;
   logic       memwb_bubble_o;
   logic [1:0] state_o;
   logic [3:0] stall_cnt_o;
   logic       err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   pipeline_hazard_ctrl #(.CNT_W(4), .TIMEOUT(8)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .ifid_uses_rt_i (ifid_uses_rt_i),
      .branch_taken_i (branch_taken_i),
      .dmem_req_i     (dmem_req_i),
      .dmem_ack_i     (dmem_ack_i),
      .pc_stall_o     (pc_stall_o),
      .ifid_stall_o   (ifid_stall_o),
      .idex_stall_o   (idex_stall_o),
      .exmem_stall_o  (exmem_stall_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_flush_o   (idex_flush_o),
      .memwb_bubble_o (memwb_bubble_o),
      .state_o        (state_o),
      .stall_cnt_o    (stall_cnt_o),
      .err_o          (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packs {pc,ifid,idex,exmem stall, ifid,idex flush, bubble} for one-shot control checks.
   function automatic logic [31:0] ctl();
      return 32'({pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
                  ifid_flush_o, idex_flush_o, memwb_bubble_o});
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      idex_memread_i = 1'b0;
      idex_rt_i      = 5'd0;
      ifid_rs_i      = 5'd0;
      ifid_rt_i      = 5'd0;
      ifid_uses_rt_i = 1'b0;
      branch_taken_i = 1'b0;
      dmem_req_i     = 1'b0;
      dmem_ack_i     = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst_i = 1'b1;
      // Load-use match during reset must not leak onto the controls.
      idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
      dmem_req_i = 1'b1;
      #2;
      chk("reset_ctl_forced", ctl(), 32'h0);
      tick(); tick();
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_cnt", 32'(stall_cnt_o), 32'd0);
      chk("reset_err", 32'(err_o), 32'd0);
      clear_inputs();
      rst_i = 1'b0;
      #1;
      chk("idle_ctl", ctl(), 32'h0);
      tick();

      // Load-use on rs: pc/ifid hold, idex bubble.
      idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
      #1;
      chk("lu_rs_ctl", ctl(), 32'b1100010);
      tick();
      clear_inputs();
      #1;
      chk("lu_rs_after_ctl", ctl(), 32'h0);
      chk("lu_rs_cnt", 32'(stall_cnt_o), 32'd1);

      // Load-use on rt, then same regs with uses_rt low, then r0.
      idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rt_i = 5'd5; ifid_rs_i = 5'd3; ifid_uses_rt_i = 1'b1;
      #1;
      chk("lu_rt_ctl", ctl(), 32'b1100010);
      tick();
      ifid_uses_rt_i = 1'b0;
      #1;
      chk("lu_rt_unused_ctl", ctl(), 32'h0);
      idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0; ifid_uses_rt_i = 1'b1;
      #1;
      chk("lu_r0_ctl", ctl(), 32'h0);
      tick();
      clear_inputs();
      chk("lu_cnt2", 32'(stall_cnt_o), 32'd2);

      // Memory stall: ack on 4th cycle -> 3 stalled cycles.
      dmem_req_i = 1'b1;
      #1;
      chk("ms_c1_ctl", ctl(), 32'b1111001);
      chk("ms_c1_state", 32'(state_o), 32'd0);
      tick();
      chk("ms_c2_ctl", ctl(), 32'b1111001);
      chk("ms_c2_state", 32'(state_o), 32'd1);
      tick();
      chk("ms_c3_ctl", ctl(), 32'b1111001);
      chk("ms_c3_state", 32'(state_o), 32'd1);
      tick();
      dmem_ack_i = 1'b1;
      #1;
      chk("ms_release_ctl", ctl(), 32'h0);
      chk("ms_release_state", 32'(state_o), 32'd1);
      tick();
      clear_inputs();
      #1;
      chk("ms_after_state", 32'(state_o), 32'd0);
      chk("ms_cnt", 32'(stall_cnt_o), 32'd5);

      // Deferred branch flush: branch in 2nd stall cycle, flush only in release cycle.
      dmem_req_i = 1'b1;
      tick();
      branch_taken_i = 1'b1;
      #1;
      chk("df_c2_ctl", ctl(), 32'b1111001);
      tick();
      branch_taken_i = 1'b0;
      #1;
      chk("df_c3_ctl", ctl(), 32'b1111001);
      tick();
      dmem_ack_i = 1'b1;
      #1;
      chk("df_release_ctl", ctl(), 32'b0000110);
      tick();
      clear_inputs();
      #1;
      chk("df_clean_ctl", ctl(), 32'h0);
      chk("df_cnt", 32'(stall_cnt_o), 32'd8);

      // Branch plus load-use: flush only.
      branch_taken_i = 1'b1; idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
      #1;
      chk("prio_ctl", ctl(), 32'b0000110);
      tick();
      clear_inputs();
      chk("prio_cnt", 32'(stall_cnt_o), 32'd8);

      // Single-cycle access.
      dmem_req_i = 1'b1; dmem_ack_i = 1'b1;
      #1;
      chk("single_ctl", ctl(), 32'h0);
      tick();
      clear_inputs();
      chk("single_state", 32'(state_o), 32'd0);

      // Timeout: clean start, then request without ack.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("to_rst_cnt", 32'(stall_cnt_o), 32'd0);
      dmem_req_i = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("to_err_before", 32'(err_o), 32'd0);
      tick();
      chk("to_err_set", 32'(err_o), 32'd1);
      chk("to_state", 32'(state_o), 32'd1);
      chk("to_still_stalled", ctl(), 32'b1111001);
      chk("to_cnt9", 32'(stall_cnt_o), 32'd9);
      for (int i = 0; i < 11; i++) tick();
      chk("sat_cnt", 32'(stall_cnt_o), 32'd15);
      chk("to_err_sticky", 32'(err_o), 32'd1);

      // Pending flush, then reset mid-wait discards it.
      branch_taken_i = 1'b1;
      tick();
      branch_taken_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("rst_ctl_forced", ctl(), 32'h0);
      tick();
      rst_i = 1'b0;
      clear_inputs();
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
      chk("rst_no_pend_flush", ctl(), 32'h0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the hold and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources: load-use data hazards, taken branches and multi-cycle data-memory accesses. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

## Interface
- `CNT_W`, default 16: width of the stall-cycle counter.
- `TIMEOUT`, default 64: number of MEM_WAIT cycles without ack before `err_o` is set.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `idex_memread_i`  in  1  instruction in ID/EX is a load.
- `idex_rt_i`  in  5  load destination register in ID/EX.
- `ifid_rs_i`  in  5  source register rs of the instruction in IF/ID.
- `ifid_rt_i`  in  5  source register rt of the instruction in IF/ID.
- `ifid_uses_rt_i`  in  1  IF/ID instruction reads rt.
- `branch_taken_i`  in  1  branch in EX resolved taken.
- `dmem_req_i`  in  1  EX/MEM instruction accesses data memory this cycle.
- `dmem_ack_i`  in  1  data memory completes the access this cycle.
- `pc_stall_o`  out  1  hold PC.
- `ifid_stall_o`  out  1  hold IF/ID.
- `idex_stall_o`  out  1  hold ID/EX.
- `exmem_stall_o`  out  1  hold EX/MEM.
- `ifid_flush_o`  out  1  load NOP into IF/ID.
- `idex_flush_o`  out  1  load bubble (all controls 0) into ID/EX.
- `memwb_bubble_o`  out  1  MEM/WB captures RegWrite=0 and MemtoReg=0.
- `state_o`  out  2  registered FSM state: 0=RUN, 1=MEM_WAIT.
- `stall_cnt_o`  out  CNT_W  registered count of cycles with `pc_stall_o`=1.
- `err_o`  out  1  registered sticky memory-timeout flag.

## Operation
- **Output timing.** Control outputs (`*_stall_o`, `*_flush_o`, `memwb_bubble_o`) are combinational from the current state, `flush_pend` and the inputs. `state_o`, `stall_cnt_o` and `err_o` are registered.
- **Memory stall.** Condition: `memstall` = `dmem_req_i` & ~`dmem_ack_i`. When it holds, in either state:
  - assert `pc_stall_o`, `ifid_stall_o`, `idex_stall_o`, `exmem_stall_o` and `memwb_bubble_o`;
  - deassert both flushes;
  - suppress load-use detection.
- **RUN → MEM_WAIT.** Taken on `memstall`. Stay in MEM_WAIT while `memstall` holds.
- **MEM_WAIT → RUN.** Taken in the cycle `dmem_ack_i`=1; this is the release cycle. In the release cycle all holds are 0 and `memwb_bubble_o`=0.
- **Deferred branch flush.** `branch_taken_i`=1 during a memory-stall cycle sets the internal register `flush_pend`.
- **Flush.** Condition: `flush_req` = ~`memstall` & (`branch_taken_i` | `flush_pend`).
  - Effect: `ifid_flush_o`=`idex_flush_o`=1.
  - `flush_pend` clears on the edge ending that cycle.
- **Load-use.** Applies when ~`memstall` & ~`flush_req` & `idex_memread_i` & `idex_rt_i`≠0 and either of:
  - `idex_rt_i`==`ifid_rs_i`;
  - `ifid_uses_rt_i` & `idex_rt_i`==`ifid_rt_i`.
- **Load-use effect.** `pc_stall_o`=`ifid_stall_o`=1 and `idex_flush_o`=1, which inserts a one-cycle bubble. EX/MEM and MEM/WB advance normally.
- **Priority.** Memory stall > branch flush > load-use.
- **Stall-cycle counter.** `stall_cnt_o` increments by 1 on every edge where `pc_stall_o`=1. It saturates at 2^CNT_W−1 and never wraps.
- **Timeout.** An internal wait counter clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT.
  - When it reaches TIMEOUT−1 with `dmem_ack_i`=0, `err_o` sets.
  - `err_o` stays set until reset. The FSM keeps waiting; there is no forced release.

## Timing
- **Reset.** With `rst_i`=1 at an edge, the following load 0: state (RUN), `flush_pend`, the wait counter, `stall_cnt_o` and `err_o`.
  - While `rst_i`=1, all control outputs are forced to 0.
  - Reset in the middle of MEM_WAIT discards a pending flush and returns to RUN on that edge.
- **Single-cycle access.** `dmem_req_i`=`dmem_ack_i`=1 in the same cycle produces no stall and stays in RUN.
- **Load-use latency.** The bubble lasts exactly 1 cycle. On the next cycle the load is in EX/MEM, so detection deasserts without any stored state.
- **Memory-stall latency.** An access acked N cycles after request gives N stalled cycles and adds N to `stall_cnt_o`.
- **Deferred flush timing.** The pending flush is issued exactly in the release cycle, never earlier.
- **Branch plus load-use.** `branch_taken_i` together with a load-use match gives flush only: `pc_stall_o`=0 and the stall count is unchanged.

## Test plan
- **Load-use stall.** Stimulus: `idex_memread_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8 for 1 cycle, then clear. Required: one cycle with `pc_stall_o`=`ifid_stall_o`=`idex_flush_o`=1, then all 0; `stall_cnt_o`=1. Repeat with `idex_rt_i`=0: no stall.
- **Memory stall.** Stimulus: `dmem_req_i`=1 held 4 cycles with `dmem_ack_i`=1 on the 4th. Required: 3 cycles with all holds and `memwb_bubble_o`=1 and `state_o`=1; release in cycle 4 with `state_o` back to 0 next; `stall_cnt_o`=3.
- **Deferred branch flush.** Stimulus: `branch_taken_i`=1 in the 2nd cycle of a memory stall. Required: no flush during the stall; `ifid_flush_o`=`idex_flush_o`=1 in the release cycle; the next cycle is clean.
- **Priority.** Stimulus: `branch_taken_i`=1 together with a load-use match in RUN. Required: flushes asserted, `pc_stall_o`=0, count unchanged.
- **Timeout and reset.** Stimulus: with TIMEOUT=8, request with no ack. Required: `err_o`=1 after the 8th MEM_WAIT cycle and still stalled. Asserting `rst_i` for 1 cycle then gives `state_o`=0, `err_o`=0 and `stall_cnt_o`=0.
- **Counter saturation.** Stimulus: with CNT_W=4, stall 20 cycles. Required: `stall_cnt_o`=15.
